button_event_ctrl: RTL and testbench
====================================

# button_event_ctrl

Per-button press sequencer placed downstream of the button debouncer. It converts debounced down/up ticks into SHORT, LONG and REPEAT events. A round-robin arbiter shares a single event FIFO between all buttons, and software or the control FSM drains it through a valid/ready read port. Timing is driven by a shared millisecond prescaler, so all hold thresholds are in milliseconds.

## Interface
Parameters:
- pARRAY_SIZE, 2: number of buttons; must match the debouncer array size.
- pCLKIN_PERIOD, 20: clock period in ns.
- pTICK_PERIOD, 1_000_000: hold-timer tick period in ns (1 ms).
- pLONG_MS, 800: hold ticks before a LONG event; range 1..65535.
- pREPEAT_MS, 200: ticks between REPEAT events after LONG; range 1..65535.
- pFIFO_DEPTH, 4: event FIFO entries; must be a power of 2, ≥2.

Ports:
- clk, in, 1: single clock; everything is synchronous to its rising edge.
- reset_n, in, 1: asynchronous assert, active-low reset.
- buttonState, in, pARRAY_SIZE: debounced level; used only for evt_held.
- buttonDwTick, in, pARRAY_SIZE: one-cycle button-down pulse.
- buttonUpTick, in, pARRAY_SIZE: one-cycle button-up pulse.
- evt_valid, out, 1: FIFO head is valid.
- evt_ready, in, 1: consumer accepts the head; pop occurs when evt_valid & evt_ready.
- evt_type, out, 2: 1 = SHORT, 2 = LONG, 3 = REPEAT; 0 is never emitted.
- evt_index, out, IDXW: button number; IDXW = max(1, clog2(pARRAY_SIZE)).
- evt_count, out, clog2(pFIFO_DEPTH)+1: current FIFO occupancy.
- evt_held, out, pARRAY_SIZE: 1 while the per-button FSM is not IDLE.
- overflow, out, 1: sticky drop flag.
- overflow_clr, in, 1: clears overflow; a set in the same cycle wins.

Reset values: evt_valid 0, evt_type 0, evt_index 0, evt_count 0, evt_held 0, overflow 0. The prescaler, all counters, pending flags and the round-robin pointer reset to 0, and every FSM resets to IDLE.

## Operation
- Prescaler:
  - Counts 0..pTICK_PERIOD/pCLKIN_PERIOD−1.
  - ms_tick is high for one cycle at wrap.
  - Free-running and shared by all buttons.
- Per-button FSM, with a 16-bit hold counter cnt:
  - IDLE: on DwTick, go to PRESSED and set cnt = 0.
  - PRESSED: on ms_tick, cnt+1. When cnt reaches pLONG_MS, raise LONG, go to LONG_HELD, set cnt = 0. On UpTick, raise SHORT and go to IDLE.
  - LONG_HELD: on ms_tick, cnt+1. When cnt reaches pREPEAT_MS, raise REPEAT and set cnt = 0. On UpTick, go to IDLE with no event.
  - Threshold check uses the incremented value, so LONG occurs on the pLONG_MS-th tick after the press.
  - UpTick and ms_tick in the same cycle: UpTick has priority; the threshold event is suppressed.
  - DwTick in a non-IDLE state: restart in PRESSED with cnt = 0 and no event.
  - UpTick in IDLE is ignored.
- Pending slot, one per button (pend flag plus pend_type):
  - A raised event loads the slot.
  - If the slot is already full, the new event is dropped and overflow is set.
- Arbiter and FIFO write:
  - When the FIFO is not full and any pend is set, grant the first pending button at or after rr_ptr, wrapping.
  - On grant, push {pend_type, index}, clear that pend, and set rr_ptr = granted+1 mod pARRAY_SIZE.
  - At most one push per cycle.
  - When full, nothing is granted and pend flags hold. The FIFO itself never drops; loss occurs only at the pending slot.
- FIFO is show-ahead: evt_type and evt_index present the head whenever evt_valid = 1.
  - Push while full is blocked even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves evt_count unchanged.
- A mid-operation reset_n assertion clears all state immediately. Events in the FIFO and pending slots are lost, and overflow is not set.

## Timing
- Tick sampled at edge k → pend set at k → FIFO push at edge k+1 → evt_valid high after edge k+1, visible in cycle k+2. This assumes an empty FIFO and a granted button.
- Contention: each additional pending button ahead in round-robin order adds 1 cycle.
- Pop takes effect at the edge where evt_valid & evt_ready; the next entry is presented in the following cycle.
- evt_held follows the FSM state with 1-cycle latency after the tick.

## Structure
- Package button_event_pkg holds:
  - EVT_SHORT, EVT_LONG, EVT_REPEAT constants.
  - The IDLE, PRESSED, LONG_HELD state encodings.
  - The IDXW and count-width helper functions.
- One sub-module, event_fifo: synchronous show-ahead FIFO with width and depth parameters, plus push, full, pop, valid and count ports.
- The FSM array, pending slots and arbiter stay in the top level, generated per button.

## Test plan
All scenarios use pCLKIN_PERIOD=10, pTICK_PERIOD=100 (ms_tick every 10 clocks), pLONG_MS=5, pREPEAT_MS=2 unless stated otherwise.
- Short press: DwTick[0], then UpTick[0] 30 clocks later → exactly one event {type 1, index 0}; evt_valid rises 2 cycles after UpTick.
- Long press with repeat: hold button 1 for 100 clocks → LONG at the 5th ms_tick, REPEAT at the 7th and 9th ms_tick; no event on release.
- Simultaneous raise: both buttons raise SHORT in the same cycle, rr_ptr=0 → FIFO order index 0 then 1; repeating the scenario with rr_ptr=1 gives order 1 then 0.
- Backpressure: evt_ready=0, 4 events fill the FIFO, 5th and 6th events arrive for button 0 → 5th waits in the pend slot, 6th drops, overflow=1, evt_count=4. After 1 pop, the 5th is pushed. overflow_clr then clears overflow.
- Priority: UpTick coinciding with the 5th ms_tick in PRESSED → SHORT only, no LONG.
- Reset: assert reset_n low with 3 events queued and button 0 in LONG_HELD → all outputs return to reset values asynchronously; no events appear after release.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared event codes, per-button state encoding and width helpers for the
// button event controller.
package button_event_pkg;

  localparam logic [1:0] EVT_SHORT  = 2'd1;
  localparam logic [1:0] EVT_LONG   = 2'd2;
  localparam logic [1:0] EVT_REPEAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } btn_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event read port: show-ahead head of the event FIFO with valid/ready pop
// and live occupancy.
interface button_event_ctrl_if #(
  parameter int IDXW = 1,
  parameter int CNTW = 3
);
  logic            evt_valid;
  logic            evt_ready;
  logic [1:0]      evt_type;
  logic [IDXW-1:0] evt_index;
  logic [CNTW-1:0] evt_count;

  modport master (
    output evt_valid, evt_type, evt_index, evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_type, evt_index, evt_count,
    output evt_ready
  );
endinterface

// File: rtl/button_event_ctrl_fifo.sv
// Synchronous show-ahead FIFO; the head reads as zero while empty and a
// push into a full FIFO is ignored even when a pop happens in that cycle.
module event_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;

  always_comb begin
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage carries data only; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Per-button SHORT/LONG/REPEAT sequencer with one pending slot per button,
// a round-robin arbiter and a shared event FIFO drained over a valid/ready port.
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter int pARRAY_SIZE   = 2,
  parameter int pCLKIN_PERIOD = 20,
  parameter int pTICK_PERIOD  = 1_000_000,
  parameter int pLONG_MS      = 800,
  parameter int pREPEAT_MS    = 200,
  parameter int pFIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [pARRAY_SIZE-1:0] buttonState,
  input  logic [pARRAY_SIZE-1:0] buttonDwTick,
  input  logic [pARRAY_SIZE-1:0] buttonUpTick,
  output logic [pARRAY_SIZE-1:0] evt_held,
  output logic                   overflow,
  input  logic                   overflow_clr,
  button_event_ctrl_if.master    evt
);

  localparam int N        = pARRAY_SIZE;
  localparam int IDXW     = idx_w(pARRAY_SIZE);
  localparam int EW       = 2 + IDXW;
  localparam int TICK_DIV = pTICK_PERIOD / pCLKIN_PERIOD;
  localparam int PSW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] LONG_TH   = 16'(pLONG_MS);
  localparam logic [15:0] REPEAT_TH = 16'(pREPEAT_MS);

  logic unused_button_state;
  assign unused_button_state = ^buttonState;

  logic [PSW-1:0] presc_q, presc_d;
  logic           ms_tick;

  assign ms_tick = (presc_q == PSW'(TICK_DIV - 1));
  assign presc_d = ms_tick ? '0 : presc_q + PSW'(1);

  logic [N-1:0]    pend_vec;
  logic [1:0]      pend_type_vec [N];
  logic [N-1:0]    drop_vec;
  logic [N-1:0]    grant;
  logic            push;
  logic [IDXW-1:0] gidx;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic            overflow_q, overflow_d;
  logic            fifo_full;
  logic [EW-1:0]   fifo_head;

  for (genvar i = 0; i < N; i++) begin : g_btn
    btn_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        raise;
    logic [1:0]  raise_type;
    logic        pend_q, pend_d;
    logic [1:0]  pend_type_q, pend_type_d;
    logic        drop;

    assign cnt_inc = cnt_q + 16'd1;

    // Down restarts from any state; up beats a coincident threshold tick.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      raise      = 1'b0;
      raise_type = EVT_SHORT;
      case (state_q)
        ST_IDLE: begin
          if (buttonDwTick[i]) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (buttonDwTick[i]) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (buttonUpTick[i]) begin
            raise      = 1'b1;
            raise_type = EVT_SHORT;
            state_d    = ST_IDLE;
          end else if (ms_tick) begin
            if (cnt_inc == LONG_TH) begin
              raise      = 1'b1;
              raise_type = EVT_LONG;
              state_d    = ST_LONG_HELD;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_LONG_HELD: begin
          if (buttonDwTick[i]) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (buttonUpTick[i]) begin
            state_d = ST_IDLE;
          end else if (ms_tick) begin
            if (cnt_inc == REPEAT_TH) begin
              raise      = 1'b1;
              raise_type = EVT_REPEAT;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A slot being granted this cycle is free to take a new event.
    always_comb begin
      pend_d      = pend_q;
      pend_type_d = pend_type_q;
      drop        = 1'b0;
      if (grant[i]) pend_d = 1'b0;
      if (raise) begin
        if (pend_q && !grant[i]) begin
          drop = 1'b1;
        end else begin
          pend_d      = 1'b1;
          pend_type_d = raise_type;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q     <= ST_IDLE;
        cnt_q       <= '0;
        pend_q      <= 1'b0;
        pend_type_q <= '0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        pend_q      <= pend_d;
        pend_type_q <= pend_type_d;
      end
    end

    assign pend_vec[i]      = pend_q;
    assign pend_type_vec[i] = pend_type_q;
    assign drop_vec[i]      = drop;
    assign evt_held[i]      = (state_q != ST_IDLE);
  end

  // Round-robin: first pending button at or after rr_ptr, nothing while full.
  always_comb begin
    int idx;
    grant = '0;
    push  = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!push && !fifo_full && pend_vec[IDXW'(idx)]) begin
        push              = 1'b1;
        grant[IDXW'(idx)] = 1'b1;
        gidx              = IDXW'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + IDXW'(1);
  end

  always_comb begin
    overflow_d = overflow_q;
    if (|drop_vec)         overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  event_fifo #(
    .WIDTH (EW),
    .DEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  ({pend_type_vec[gidx], gidx}),
    .full_o  (fifo_full),
    .pop_i   (evt.evt_ready),
    .valid_o (evt.evt_valid),
    .data_o  (fifo_head),
    .count_o (evt.evt_count)
  );

  assign evt.evt_type  = fifo_head[EW-1 -: 2];
  assign evt.evt_index = fifo_head[IDXW-1:0];

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench: stimulus queues expected events, a negedge monitor pops
// and compares every accepted FIFO head.
module tb_button_event_ctrl;
  import button_event_pkg::*;

  localparam int N = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] bstate, dw, up;
  logic [N-1:0] held;
  logic         overflow, ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  logic [2:0] exp_q [$];

  button_event_ctrl_if #(.IDXW(idx_w(N)), .CNTW(cnt_w(D))) bus ();

  button_event_ctrl #(
    .pARRAY_SIZE   (N),
    .pCLKIN_PERIOD (10),
    .pTICK_PERIOD  (100),
    .pLONG_MS      (5),
    .pREPEAT_MS    (2),
    .pFIFO_DEPTH   (D)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .buttonState  (bstate),
    .buttonDwTick (dw),
    .buttonUpTick (up),
    .evt_held     (held),
    .overflow     (overflow),
    .overflow_clr (ovf_clr),
    .evt          (bus)
  );

  always #5 clk = ~clk;

  // Edges since reset release; ms_tick is sampled on edges where cyc % 10 == 0.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [2:0] ev(input logic [1:0] t, input int b);
    return {t, b[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic short_press(input int b);
    dw[b] = 1'b1; bstate[b] = 1'b1;
    step();
    dw = '0;
    step();
    up[b] = 1'b1; bstate[b] = 1'b0;
    step();
    up = '0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    int'(bus.evt_valid), 0);
    check({tag, "_type"},     int'(bus.evt_type),  0);
    check({tag, "_index"},    int'(bus.evt_index), 0);
    check({tag, "_count"},    int'(bus.evt_count), 0);
    check({tag, "_held"},     int'(held),          0);
    check({tag, "_overflow"}, int'(overflow),      0);
  endtask

  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.evt_valid && bus.evt_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got type=%0d index=%0d, required no event",
                   bus.evt_type, bus.evt_index);
        end else begin
          e = exp_q.pop_front();
          check("evt_type",  int'(bus.evt_type),  int'(e[2:1]));
          check("evt_index", int'(bus.evt_index), int'(e[0]));
        end
      end
    end
  end

  initial begin
    dw = '0; up = '0; bstate = '0; ovf_clr = 1'b0;
    bus.evt_ready = 1'b1;

    #1 reset_n = 1'b0;
    #10 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // Short press on button 0.
    dw[0] = 1'b1; bstate[0] = 1'b1;
    step();
    dw = '0;
    check("held_after_dw", int'(held[0]), 1);
    repeat (29) step();
    up[0] = 1'b1; bstate[0] = 1'b0;
    exp_q.push_back(ev(EVT_SHORT, 0));
    step();
    up = '0;
    check("short_valid_at_k", int'(bus.evt_valid), 0);
    check("held_after_up", int'(held[0]), 0);
    step();
    check("short_valid_at_k1", int'(bus.evt_valid), 1);
    repeat (5) step();
    check("short_count_empty", int'(bus.evt_count), 0);

    // Long hold on button 1: LONG then two REPEATs, nothing on release.
    exp_q.push_back(ev(EVT_LONG, 1));
    exp_q.push_back(ev(EVT_REPEAT, 1));
    exp_q.push_back(ev(EVT_REPEAT, 1));
    dw[1] = 1'b1; bstate[1] = 1'b1;
    step();
    dw = '0;
    repeat (99) step();
    check("long_held", int'(held[1]), 1);
    up[1] = 1'b1; bstate[1] = 1'b0;
    step();
    up = '0;
    check("long_released", int'(held[1]), 0);
    repeat (10) step();
    check("long_events_seen", exp_q.size(), 0);

    // Simultaneous SHORTs with rr_ptr=0, then with rr_ptr=1.
    exp_q.push_back(ev(EVT_SHORT, 0));
    exp_q.push_back(ev(EVT_SHORT, 1));
    dw = 2'b11; step(); dw = '0; step();
    up = 2'b11; step(); up = '0;
    repeat (6) step();
    check("rr0_order_done", exp_q.size(), 0);
    exp_q.push_back(ev(EVT_SHORT, 0));
    short_press(0);
    repeat (4) step();
    exp_q.push_back(ev(EVT_SHORT, 1));
    exp_q.push_back(ev(EVT_SHORT, 0));
    dw = 2'b11; step(); dw = '0; step();
    up = 2'b11; step(); up = '0;
    repeat (6) step();
    check("rr1_order_done", exp_q.size(), 0);

    // Release on the 5th ms_tick: SHORT only.
    while (cyc % 10 != 0) step();
    dw[0] = 1'b1;
    step();
    dw = '0;
    repeat (48) step();
    up[0] = 1'b1;
    exp_q.push_back(ev(EVT_SHORT, 0));
    step();
    up = '0;
    check("prio_held_cleared", int'(held[0]), 0);
    repeat (6) step();
    check("prio_short_only", exp_q.size(), 0);

    // Backpressure: fill, park one in the pend slot, drop one.
    bus.evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ev(EVT_SHORT, 0));
      short_press(0);
    end
    step();
    check("bp_count_full", int'(bus.evt_count), 4);
    check("bp_overflow_clear", int'(overflow), 0);
    exp_q.push_back(ev(EVT_SHORT, 0));
    short_press(0);
    step();
    check("bp_fifth_waits", int'(bus.evt_count), 4);
    check("bp_fifth_no_ovf", int'(overflow), 0);
    short_press(0);
    check("bp_overflow_set", int'(overflow), 1);
    check("bp_count_still_full", int'(bus.evt_count), 4);
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    check("bp_after_pop", int'(bus.evt_count), 3);
    step();
    check("bp_pend_pushed", int'(bus.evt_count), 4);
    check("bp_overflow_sticky", int'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("bp_overflow_cleared", int'(overflow), 0);
    bus.evt_ready = 1'b1;
    repeat (8) step();
    check("bp_drained_count", int'(bus.evt_count), 0);
    check("bp_drained_queue", exp_q.size(), 0);

    // Mid-operation reset with 3 queued events and button 0 in LONG_HELD.
    bus.evt_ready = 1'b0;
    short_press(1);
    short_press(1);
    dw[0] = 1'b1; bstate[0] = 1'b1;
    step();
    dw = '0;
    repeat (55) step();
    check("rst_pre_count", int'(bus.evt_count), 3);
    check("rst_pre_held", int'(held[0]), 1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    bstate = '0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    bus.evt_ready = 1'b1;
    repeat (60) step();
    check("post_reset_count", int'(bus.evt_count), 0);
    check("post_reset_held", int'(held), 0);

    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
        step();
        guard++;
      end
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
